// File: rtl/axis_rr_arbiter.sv
// Round-robin arbiter that merges NUM_PORTS AXI4-Stream sources onto one sink.
// A grant lasts at most MAX_BURST beats and is always followed by one IDLE cycle.
module axis_rr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_PORTS  = 4,
    parameter int MAX_BURST  = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
    output logic [NUM_PORTS-1:0]            s_axis_tready,
    output logic [DATA_WIDTH-1:0]           m_axis_tdata,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic [$clog2(NUM_PORTS)-1:0]    grant_id,
    output logic                            grant_active
);

    localparam int ID_W  = $clog2(NUM_PORTS);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t            state;
    logic [ID_W-1:0]   last_grant;
    logic [CNT_W-1:0]  beat_cnt;

    logic [DATA_WIDTH-1:0] port_data [NUM_PORTS];
    logic [ID_W-1:0]       cand;
    logic [ID_W-1:0]       next_port;
    logic                  found;
    logic                  active;
    logic                  sel_valid;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_unpack
        assign port_data[i] = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // Scan from the port after the last winner, wrapping, so the most recent
    // winner is always considered last.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        found     = 1'b0;
        next_port = last_grant;
        cand      = last_grant;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            cand = ID_W'((int'(last_grant) + k) % NUM_PORTS);
            if (!found && s_axis_tvalid[cand]) begin
                found     = 1'b1;
                next_port = cand;
            end
        end
    end

    // Datapath is a pure mux; forced quiet while reset is asserted.
    assign active       = (state == GRANT) && !rst;
    assign sel_valid    = s_axis_tvalid[grant_id];
    assign grant_active = active;

    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tvalid = 1'b0;
        s_axis_tready = '0;
        if (active) begin
            m_axis_tdata            = port_data[grant_id];
            m_axis_tvalid           = sel_valid;
            s_axis_tready[grant_id] = m_axis_tready;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state      <= IDLE;
            grant_id   <= '0;
            last_grant <= ID_W'(NUM_PORTS - 1);
            beat_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        grant_id   <= next_port;
                        last_grant <= next_port;
                        beat_cnt   <= '0;
                        state      <= GRANT;
                    end
                end
                GRANT: begin
                    // A stalled beat (valid high, ready low) keeps the grant.
                    if (!sel_valid) begin
                        state <= IDLE;
                    end else if (m_axis_tready) begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                        if (beat_cnt == CNT_W'(MAX_BURST - 1)) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Bench for axis_rr_arbiter: directed scenarios plus random traffic, checked
// each cycle against a transaction-level owner/pointer model and per-port FIFOs.
module tb_axis_rr_arbiter;

    localparam int DW = 8;
    localparam int NP = 4;
    localparam int MB = 4;
    localparam int IW = $clog2(NP);

    logic              clk = 1'b0;
    logic              rst;
    logic [NP*DW-1:0]  s_axis_tdata;
    logic [NP-1:0]     s_axis_tvalid;
    logic [NP-1:0]     s_axis_tready;
    logic [DW-1:0]     m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic [IW-1:0]     grant_id;
    logic              grant_active;

    axis_rr_arbiter #(.DATA_WIDTH(DW), .NUM_PORTS(NP), .MAX_BURST(MB)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .grant_id      (grant_id),
        .grant_active  (grant_active)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Source FIFOs: front entry is what each requester currently presents.
    logic [DW-1:0] src_q [NP][$];
    logic [NP-1:0] want;

    // Model: owner = granted port or -1, beats in this grant, rr pointer.
    int m_owner = -1;
    int m_beats = 0;
    int m_ptr   = NP - 1;
    int m_gid   = 0;

    int   grants [$];
    int   bursts [$];
    logic prev_act = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NP; i++) begin
            s_axis_tvalid[i]         = want[i] && (src_q[i].size() > 0);
            s_axis_tdata[i*DW +: DW] = (src_q[i].size() > 0) ? src_q[i][0] : '0;
        end
    endtask

    task automatic step(input logic r, input logic rdy);
        logic          exp_act;
        logic          exp_valid;
        logic [NP-1:0] exp_ready;
        logic [DW-1:0] exp_data;
        rst           = r;
        m_axis_tready = rdy;
        drive();
        @(negedge clk);

        exp_act   = !r && (m_owner >= 0);
        exp_valid = 1'b0;
        exp_ready = '0;
        exp_data  = '0;
        if (exp_act) begin
            exp_valid          = s_axis_tvalid[m_owner];
            exp_ready[m_owner] = rdy;
            exp_data           = (src_q[m_owner].size() > 0) ? src_q[m_owner][0] : '0;
        end
        check("grant_active", 32'(grant_active), 32'(exp_act));
        check("m_tvalid", 32'(m_axis_tvalid), 32'(exp_valid));
        check("s_tready", 32'(s_axis_tready), 32'(exp_ready));
        check("m_tdata", 32'(m_axis_tdata), 32'(exp_data));
        if (!r) check("grant_id", 32'(grant_id), 32'(m_gid));

        if (grant_active && !prev_act) begin
            grants.push_back(int'(grant_id));
            bursts.push_back(0);
        end
        if (grant_active && m_axis_tvalid && rdy && bursts.size() > 0)
            bursts[bursts.size()-1]++;
        prev_act = grant_active;

        if (r) begin
            m_owner = -1; m_beats = 0; m_ptr = NP - 1; m_gid = 0;
        end else if (m_owner < 0) begin
            for (int k = 1; k <= NP; k++) begin
                if (m_owner < 0 && s_axis_tvalid[(m_ptr + k) % NP]) begin
                    m_owner = (m_ptr + k) % NP;
                    m_ptr   = m_owner;
                    m_gid   = m_owner;
                    m_beats = 0;
                end
            end
        end else if (!s_axis_tvalid[m_owner]) begin
            m_owner = -1;
        end else if (rdy) begin
            void'(src_q[m_owner].pop_front());
            m_beats++;
            if (m_beats == MB) m_owner = -1;
        end

        @(posedge clk);
        #1;
    endtask

    task automatic clear_all();
        for (int i = 0; i < NP; i++) src_q[i].delete();
        grants.delete();
        bursts.delete();
    endtask

    initial begin
        rst = 1'b1; m_axis_tready = 1'b0; want = '0;
        s_axis_tvalid = '0; s_axis_tdata = '0;

        // Reset state.
        step(1, 1); step(1, 1);
        step(0, 1);

        // Port 2 alone, 10 beats -> 4,4,2.
        clear_all();
        want = '1;
        for (int d = 0; d < 10; d++) src_q[2].push_back(DW'(d));
        for (int c = 0; c < 16; c++) step(0, 1);
        check("s21_nbursts", bursts.size(), 3);
        if (bursts.size() == 3) begin
            check("s21_b0", bursts[0], 4);
            check("s21_b1", bursts[1], 4);
            check("s21_b2", bursts[2], 2);
        end
        check("s21_grant0", (grants.size() > 0) ? grants[0] : -1, 2);

        // All four ports continuously valid after reset.
        clear_all();
        for (int i = 0; i < NP; i++)
            for (int d = 0; d < 2*MB; d++) src_q[i].push_back(DW'(16*i + d));
        step(1, 1);
        grants.delete(); bursts.delete();
        for (int c = 0; c < 45; c++) step(0, 1);
        check("s22_ngrants", grants.size(), 8);
        for (int g = 0; g < 8 && g < grants.size(); g++) begin
            check("s22_order", grants[g], g % NP);
            check("s22_len", bursts[g], MB);
        end

        // Sink stall after 2nd beat of a port-1 burst.
        clear_all();
        for (int d = 0; d < MB; d++) src_q[1].push_back(DW'(8'hA0 + d));
        step(1, 1);
        step(0, 1); step(0, 1); step(0, 1);
        for (int c = 0; c < 5; c++) step(0, 0);
        for (int c = 0; c < 4; c++) step(0, 1);
        check("s23_drained", src_q[1].size(), 0);
        check("s23_ngrants", grants.size(), 1);

        // Port 0 dries up after 2 beats, port 3 waiting.
        clear_all();
        src_q[0].push_back(8'h11); src_q[0].push_back(8'h12);
        for (int d = 0; d < MB; d++) src_q[3].push_back(DW'(8'h30 + d));
        step(1, 1);
        for (int c = 0; c < 12; c++) step(0, 1);
        check("s24_ngrants", grants.size(), 2);
        if (grants.size() == 2) check("s24_second", grants[1], 3);
        check("s24_drained", src_q[3].size(), 0);

        // Reset pulse during the 3rd beat of a port-2 burst.
        clear_all();
        for (int i = 0; i < NP; i++)
            for (int d = 0; d < 2*MB; d++) src_q[i].push_back(DW'(8'h80 + 16*i + d));
        step(1, 1);
        for (int c = 0; c < 13; c++) step(0, 1);
        step(1, 1);
        grants.delete(); bursts.delete();
        for (int c = 0; c < 6; c++) step(0, 1);
        check("s25_first", (grants.size() > 0) ? grants[0] : -1, 0);

        // Port 1 finishes a burst while ports 1 and 2 both request.
        clear_all();
        for (int d = 0; d < 2*MB; d++) src_q[1].push_back(DW'(8'h50 + d));
        for (int d = 0; d < MB; d++) src_q[2].push_back(DW'(8'h60 + d));
        step(1, 1);
        for (int c = 0; c < 16; c++) step(0, 1);
        check("s26_ngrants", grants.size(), 3);
        if (grants.size() == 3) begin
            check("s26_g0", grants[0], 1);
            check("s26_g1", grants[1], 2);
            check("s26_g2", grants[2], 1);
        end

        // Random traffic, stalls and occasional resets.
        clear_all();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NP; i++)
                if ($urandom_range(7) == 0 && src_q[i].size() < 12)
                    for (int d = 0; d < int'($urandom_range(6)); d++)
                        src_q[i].push_back(DW'($urandom_range(255)));
            want = NP'($urandom);
            step($urandom_range(199) == 0, $urandom_range(3) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axis_rr_arbiter.md
AXIS_RR_ARBITER -- requirements
Module: axis_rr_arbiter

Interface
REQ-001 Parameters SHALL be, one per line:
  DATA_WIDTH  8  width of each stream's tdata
  NUM_PORTS  4  number of AXI4-Stream requesters, >=2
  MAX_BURST  4  maximum beats per grant, >=1
REQ-002 Clocking SHALL be one clock; reset is synchronous and active-high.
REQ-003 Ports SHALL be, one per line:
  clk  input  1  clock, all state on rising edge
  rst  input  1  synchronous active-high reset
  s_axis_tdata  input  NUM_PORTS*DATA_WIDTH  requester data, port i at bits [i*DATA_WIDTH +: DATA_WIDTH]
  s_axis_tvalid  input  NUM_PORTS  requester valid, bit i = port i
  s_axis_tready  output  NUM_PORTS  requester ready, bit i = port i
  m_axis_tdata  output  DATA_WIDTH  shared sink data (e.g. UART TX)
  m_axis_tvalid  output  1  shared sink valid
  m_axis_tready  input  1  shared sink ready
  grant_id  output  $clog2(NUM_PORTS)  index of the granted port
  grant_active  output  1  a grant is held

Function
REQ-004 FSM SHALL have two states: IDLE and GRANT.
REQ-005 In IDLE: grant_active=0, m_axis_tvalid=0, s_axis_tready=0 on all bits.
REQ-006 In IDLE with any s_axis_tvalid high, the arbiter SHALL select the first valid port scanning (last_grant+1) mod NUM_PORTS upward with wrap, register it into grant_id and last_grant, clear beat_cnt, and enter GRANT on the next cycle.
REQ-007 In IDLE with no valid, state, grant_id and last_grant SHALL hold.
REQ-008 In GRANT: grant_active=1; m_axis_tdata = data of port grant_id; m_axis_tvalid = s_axis_tvalid[grant_id]; s_axis_tready[grant_id] = m_axis_tready; all other s_axis_tready bits = 0; these paths SHALL be combinational, zero-cycle.
REQ-009 A beat SHALL be counted when m_axis_tvalid && m_axis_tready; beat_cnt width $clog2(MAX_BURST+1), saturation is never reached.
REQ-010 GRANT SHALL exit to IDLE when the handshake completing beat MAX_BURST occurs.
REQ-011 GRANT SHALL exit to IDLE in any cycle with s_axis_tvalid[grant_id]=0 (source has no data).
REQ-012 The grant SHALL NOT be released while s_axis_tvalid[grant_id]=1 and m_axis_tready=0 (no beat abandoned mid-handshake).
REQ-013 Each grant SHALL be followed by exactly one IDLE cycle, so arbitration latency is 1 cycle from IDLE to first possible beat.
REQ-014 Requests arriving during GRANT SHALL be considered only at the next IDLE cycle; a release and a new request in the same cycle SHALL produce a grant one cycle later.
REQ-015 Beat ordering within a port SHALL be preserved; no beat SHALL be duplicated or dropped.
REQ-016 With all ports continuously valid, each port SHALL receive one grant per NUM_PORTS grants (strict round-robin, starvation-free).
REQ-017 The design SHALL be pure AXI4-Stream. There is no tlast, so packets are not kept atomic beyond MAX_BURST.

Reset
REQ-018 While rst=1 at a clock edge: state=IDLE, grant_id=0, grant_active=0, beat_cnt=0, last_grant=NUM_PORTS-1, so port 0 has first priority.
REQ-019 During reset, m_axis_tvalid=0, s_axis_tready=0 and m_axis_tdata=0 SHALL hold.
REQ-020 Reset asserted mid-burst SHALL abort the grant in the cycle after the edge. Source-side beats already handshaken stay delivered; no partial beat is issued.

Verification (NUM_PORTS=4, MAX_BURST=4, DATA_WIDTH=8)
REQ-021 Port 2 alone sends 10 beats 0x00..0x09, m_axis_tready=1 -> bursts of 4,4,2 beats on m_axis with grant_id=2 and one bubble cycle between bursts; data in order.
REQ-022 All four ports continuously valid after reset -> grant_id sequence 0,1,2,3,0,...; each grant 4 beats; every 5th cycle idle.
REQ-023 m_axis_tready held low 5 cycles after the 2nd beat of a port-1 burst -> m_axis_tdata/tvalid stable, s_axis_tready[1]=0, grant held, then beats 3-4 complete with no loss.
REQ-024 Port 0 drops tvalid after 2 beats while port 3 valid -> release next cycle, IDLE 1 cycle, then grant_id=3.
REQ-025 rst pulsed for 1 cycle during the 3rd beat of a port-2 burst with all ports valid -> next cycle all outputs 0, then grant_id=0 first.
REQ-026 Port 1 releases on beat 4 in the same cycle port 1 and port 2 request -> next grant is port 2 (round-robin pointer), not port 1.
